// File: rtl/axi4_lite_read_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4_lite_read_slave_mem
// AXI4-Lite read-only slave backed by a 64-bit word-addressed memory.
// Accepts one AR request at a time and returns the R beat after a programmable
// number of wait cycles. Misaligned addresses answer SLVERR and out-of-range
// addresses answer DECERR; both return zero data, and SLVERR wins when both
// apply. A sideband write port preloads the memory in any state.
//
// Optional feature: define AXI_RD_SLV_RAND_DELAY_EN to add 0..3 extra wait
// cycles per read, taken from an 8-bit Fibonacci LFSR (taps 8,6,5,4).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi4_lite_read_slave_mem #(
  parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [63:0]           AR_ADDR,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  output logic [63:0]           R_DATA,
  output logic [1:0]            R_RESP,
  output logic                  R_VALID,
  input  logic                  R_READY,
  input  logic                  MEM_WE,
  input  logic [DEPTH_LOG2-1:0] MEM_WADDR,
  input  logic [63:0]           MEM_WDATA
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [63:0] DEPTH_W = 64'd1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [8:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [1:0]              resp_q, resp_d;
  logic                    ar_ready_q, ar_ready_d;
  logic                    r_valid_q, r_valid_d;
  logic [63:0]             r_data_q, r_data_d;
  logic [1:0]              r_resp_q, r_resp_d;

  logic [63:0]             mem_q [DEPTH];
  logic [63:0]             mem_rd_s;

  logic [63:0]             off_s;
  logic [63:0]             off_word_s;
  logic                    misal_s;
  logic                    oor_s;
  logic [1:0]              dec_resp_s;
  logic [8:0]              extra_s;

`ifdef AXI_RD_SLV_RAND_DELAY_EN
  logic [7:0]              lfsr_q, lfsr_d;
  logic                    lfsr_fb_s;

  // LFSR next state: shift left, feedback from taps 8,6,5,4
  always_comb begin
    lfsr_fb_s = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d    = {lfsr_q[6:0], lfsr_fb_s};
    extra_s   = {7'd0, lfsr_q[1:0]};
  end

  // LFSR register, advances every cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign extra_s = 9'd0;
`endif

  // Address decode of the incoming AR address; used only at the handshake
  always_comb begin
    off_s      = AR_ADDR - BASE_ADDR;
    off_word_s = off_s >> 3;
    misal_s    = (AR_ADDR[2:0] != 3'd0);
    oor_s      = (AR_ADDR < BASE_ADDR) || (off_word_s >= DEPTH_W);
    if (misal_s) begin
      dec_resp_s = RESP_SLVERR;
    end else if (oor_s) begin
      dec_resp_s = RESP_DECERR;
    end else begin
      dec_resp_s = RESP_OKAY;
    end
  end

  // Asynchronous read of the latched word; sampled into R_DATA on WAIT->RESP,
  // so a same-cycle preload write to that word returns the old contents
  assign mem_rd_s = mem_q[idx_q];

  // Preload write port, active in every state; contents are not reset
  always_ff @(posedge CLK) begin
    if (MEM_WE) begin
      mem_q[MEM_WADDR] <= MEM_WDATA;
    end
  end

  // FSM next-state and output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    resp_d     = resp_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (AR_VALID && ar_ready_q) begin
          idx_d      = off_word_s[DEPTH_LOG2-1:0];
          resp_d     = dec_resp_s;
          cnt_d      = 9'(READ_LATENCY) + extra_s;
          ar_ready_d = 1'b0;
          state_d    = ST_WAIT;
        end else begin
          ar_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 9'd0) begin
          r_valid_d = 1'b1;
          r_resp_d  = resp_q;
          r_data_d  = (resp_q == RESP_OKAY) ? mem_rd_s : 64'd0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      ST_RESP: begin
        if (r_valid_q && R_READY) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          r_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        ar_ready_d = 1'b1;
        r_valid_d  = 1'b0;
        cnt_d      = 9'd0;
      end
    endcase
  end

  // FSM and registered-output state; reset drops any pending read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 9'd0;
      idx_q      <= '0;
      resp_q     <= RESP_OKAY;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_data_q   <= 64'd0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      resp_q     <= resp_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign AR_READY = ar_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign R_RESP   = r_resp_q;

endmodule

// File: tb/tb_axi4_lite_read_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_read_slave_mem
// Scoreboard bench: the driver pushes the expected R beat (from a reference
// memory model and the address decode rules) at each AR handshake; a monitor
// pops and compares on each R handshake and also checks latency, R stability
// under backpressure and AR_READY behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axi4_lite_read_slave_mem;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DL2   = 10;
  localparam int          DEPTH = 1 << DL2;
  localparam int          RL    = 2;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          hs;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [63:0]     AR_ADDR = 64'd0;
  logic            AR_VALID = 1'b0;
  logic            AR_READY;
  logic [63:0]     R_DATA;
  logic [1:0]      R_RESP;
  logic            R_VALID;
  logic            R_READY = 1'b0;
  logic            MEM_WE = 1'b0;
  logic [DL2-1:0]  MEM_WADDR = '0;
  logic [63:0]     MEM_WDATA = 64'd0;

  logic [63:0]     ref_mem [DEPTH];
  exp_t            exp_q [$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              min_lat = 1000;
  int              max_lat = 0;

  axi4_lite_read_slave_mem #(
    .BASE_ADDR    (BASE),
    .DEPTH_LOG2   (DL2),
    .READ_LATENCY (RL)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .AR_ADDR   (AR_ADDR),
    .AR_VALID  (AR_VALID),
    .AR_READY  (AR_READY),
    .R_DATA    (R_DATA),
    .R_RESP    (R_RESP),
    .R_VALID   (R_VALID),
    .R_READY   (R_READY),
    .MEM_WE    (MEM_WE),
    .MEM_WADDR (MEM_WADDR),
    .MEM_WDATA (MEM_WDATA)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: alignment first, then range, then memory lookup
  function automatic exp_t model(input logic [63:0] a);
    exp_t e;
    e.hs = 0;
    if (a % 64'd8 != 64'd0) begin
      e.resp = 2'b10;
      e.data = 64'd0;
    end else if (a < BASE || (a - BASE) / 64'd8 >= 64'(DEPTH)) begin
      e.resp = 2'b11;
      e.data = 64'd0;
    end else begin
      e.resp = 2'b00;
      e.data = ref_mem[int'((a - BASE) / 64'd8)];
    end
    return e;
  endfunction

  // Called at a negedge; returns at a negedge
  task automatic mem_write(input int idx, input logic [63:0] d);
    MEM_WE = 1'b1;
    MEM_WADDR = DL2'(idx);
    MEM_WDATA = d;
    ref_mem[idx] = d;
    @(posedge CLK);
    @(negedge CLK);
    MEM_WE = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the R handshake
  task automatic do_read(input logic [63:0] a, input int hold, input bit garbage);
    exp_t e;
    int k;
    k = 0;
    while (!AR_READY && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (!AR_READY) begin
      check("ar_ready_timeout", {63'd0, AR_READY}, 64'd1);
      return;
    end
    AR_VALID = 1'b1;
    AR_ADDR  = a;
    @(posedge CLK);
    @(negedge CLK);
    e = model(a);
    e.hs = cyc;
    exp_q.push_back(e);
    AR_VALID = garbage;
    AR_ADDR  = {$urandom, $urandom};
    k = 0;
    while (!R_VALID && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (!R_VALID) begin
      AR_VALID = 1'b0;
      check("r_valid_timeout", {63'd0, R_VALID}, 64'd1);
      return;
    end
    repeat (hold) @(negedge CLK);
    R_READY  = 1'b1;
    AR_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    R_READY = 1'b0;
  endtask

  // Monitor: samples 1ns after each negedge, away from the active edge
  initial begin
    bit          prev_v;
    bit          popped;
    logic [63:0] hd;
    logic [1:0]  hr;
    exp_t        e;
    int          lat;
    prev_v = 1'b0;
    popped = 1'b0;
    hd = 64'd0;
    hr = 2'b00;
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        prev_v = 1'b0;
        popped = 1'b0;
      end else begin
        if (popped) check("ar_ready_after_r_hs", {63'd0, AR_READY}, 64'd1);
        popped = 1'b0;
        if (exp_q.size() > 0) check("ar_ready_busy", {63'd0, AR_READY}, 64'd0);
        if (R_VALID && !prev_v) begin
          if (exp_q.size() == 0) begin
            check("unexpected_r_valid", {63'd0, R_VALID}, 64'd0);
          end else begin
            lat = cyc - exp_q[0].hs;
            if (lat < min_lat) min_lat = lat;
            if (lat > max_lat) max_lat = lat;
`ifdef AXI_RD_SLV_RAND_DELAY_EN
            check("latency_in_range", {63'd0, (lat >= RL + 1 && lat <= RL + 4)}, 64'd1);
`else
            check("latency", 64'(lat), 64'(RL + 1));
`endif
          end
          hd = R_DATA;
          hr = R_RESP;
        end else if (R_VALID) begin
          check("r_data_stable", R_DATA, hd);
          check("r_resp_stable", {62'd0, R_RESP}, {62'd0, hr});
        end
        if (R_VALID && R_READY) begin
          if (exp_q.size() == 0) begin
            check("r_beat_without_request", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("r_data", R_DATA, e.data);
            check("r_resp", {62'd0, R_RESP}, {62'd0, e.resp});
          end
          popped = 1'b1;
        end
        prev_v = R_VALID;
      end
    end
  end

  initial begin
    logic [63:0] a;
    int          r;
    int          idx;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_r_valid", {63'd0, R_VALID}, 64'd0);
    check("rst_ar_ready", {63'd0, AR_READY}, 64'd1);
    check("rst_r_data", R_DATA, 64'd0);
    check("rst_r_resp", {62'd0, R_RESP}, 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Preload every word with random data (back-to-back writes)
    for (int i = 0; i < DEPTH; i++) begin
      MEM_WE = 1'b1;
      MEM_WADDR = DL2'(i);
      MEM_WDATA = {$urandom, $urandom};
      ref_mem[i] = MEM_WDATA;
      @(negedge CLK);
    end
    MEM_WE = 1'b0;

    // 1) basic OKAY read of word 0
    mem_write(0, 64'h1122_3344_5566_7788);
    do_read(BASE, 0, 1'b0);

    // 2) out-of-range: one past the end, just below base, extremes
    do_read(BASE + 64'(8 * DEPTH), 0, 1'b0);
    do_read(BASE - 64'd8, 0, 1'b0);
    do_read(64'd0, 0, 1'b0);
    do_read(64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b0);
    do_read(BASE + 64'(8 * (DEPTH - 1)), 0, 1'b0);

    // 3) misaligned, in range and out of range (SLVERR wins)
    do_read(BASE + 64'd4, 0, 1'b0);
    do_read(BASE - 64'd3, 0, 1'b0);

    // 4) backpressure for 5 cycles with AR_VALID asserted while busy
    do_read(BASE + 64'd16, 5, 1'b1);

    // 5) reset while the read is waiting
    AR_VALID = 1'b1;
    AR_ADDR  = BASE + 64'd8;
    @(posedge CLK);
    @(negedge CLK);
    AR_VALID = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_r_valid", {63'd0, R_VALID}, 64'd0);
    check("midrst_ar_ready", {63'd0, AR_READY}, 64'd1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    do_read(BASE + 64'd8, 0, 1'b0);

    // 6) 100 reads of mem[k] = k with R_READY promptly accepted
    for (int k = 0; k < 100; k++) mem_write(k, 64'(k));
    for (int k = 0; k < 100; k++) do_read(BASE + 64'(8 * k), 0, 1'b0);

    // Randomised mix of addresses, backpressure and interleaved preloads
    for (int n = 0; n < 150; n++) begin
      r   = $urandom_range(0, 9);
      idx = $urandom_range(0, DEPTH - 1);
      case (r)
        6:       a = BASE + 64'(8 * idx) + 64'($urandom_range(1, 7));
        7:       a = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 1000));
        8:       a = BASE - 64'(8 * $urandom_range(1, 1000));
        9:       a = BASE + 64'(8 * DEPTH) + 64'($urandom_range(1, 7));
        default: a = BASE + 64'(8 * idx);
      endcase
      if ($urandom_range(0, 3) == 0) mem_write(idx, {$urandom, $urandom});
      do_read(a, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("min_latency", 64'(min_lat), 64'(RL + 1));
`ifdef AXI_RD_SLV_RAND_DELAY_EN
    check("max_latency", 64'(max_lat), 64'(RL + 4));
`else
    check("max_latency", 64'(max_lat), 64'(RL + 1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
